change_dispenser: RTL and testbench

Coin-payout engine for the vending machine: the outbound counterpart of the coin-accepting FSM. It accepts a change-amount request (rupees) over a valid/ready handshake and drives timed eject pulses to the Rs.10 and Rs.5 coin hoppers, greedy largest-first. It tracks hopper inventory and reports any unpaid shortfall. It sits between the sale controller and the hopper solenoid drivers.

---
 rtl/vm_coin_pkg.sv | 16 +
 rtl/eject_timer.sv | 28 ++
 rtl/change_dispenser.sv | 146 ++++++++++++++
 tb/tb_change_dispenser.sv | 238 +++++++++++++++++++++++
 4 files changed

// File: rtl/vm_coin_pkg.sv
// Shared coin constants and payout FSM state encoding for the vending machine.
package vm_coin_pkg;

    localparam int unsigned COIN5  = 5;
    localparam int unsigned COIN10 = 10;

    typedef enum logic [2:0] {
        StIdle,
        StCheck,
        StEject10,
        StEject5,
        StGap,
        StDone
    } disp_state_e;

endpackage

// File: rtl/eject_timer.sv
// Loadable down-counter. The FSM loads it on entry to a timed phase and
// advances when it reads zero, so a load value of N-1 gives an N-cycle phase.
module eject_timer #(
    parameter int unsigned W = 2
) (
    input  logic         clk,
    input  logic         reset_n,
    input  logic         load,
    input  logic [W-1:0] load_val,
    output logic         expired
);

    logic [W-1:0] cnt_q;

    // Count down to zero and hold there until reloaded.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            cnt_q <= '0;
        end else if (load) begin
            cnt_q <= load_val;
        end else if (cnt_q != '0) begin
            cnt_q <= cnt_q - 1'b1;
        end
    end

    assign expired = (cnt_q == '0);

endmodule

// File: rtl/change_dispenser.sv
// Coin-payout engine: pays a requested amount greedily with Rs.10 then Rs.5
// coins via timed hopper eject pulses, tracking inventory and shortfall.
module change_dispenser
    import vm_coin_pkg::*;
#(
    parameter int unsigned AMT_W        = 8,
    parameter int unsigned INV_W        = 8,
    parameter int unsigned PULSE_CYCLES = 4,
    parameter int unsigned GAP_CYCLES   = 4,
    parameter int unsigned INV5_INIT    = 20,
    parameter int unsigned INV10_INIT   = 20
) (
    input  logic             clk,
    input  logic             reset_n,
    input  logic             req_valid,
    input  logic [AMT_W-1:0] req_amount,
    output logic             req_ready,
    input  logic             refill_valid,
    input  logic [INV_W-1:0] refill_cnt5,
    input  logic [INV_W-1:0] refill_cnt10,
    output logic             eject_5,
    output logic             eject_10,
    output logic             busy,
    output logic             done,
    output logic [AMT_W-1:0] shortfall,
    output logic [INV_W-1:0] inv5,
    output logic [INV_W-1:0] inv10
);

    localparam int unsigned MAX_CYC = (PULSE_CYCLES > GAP_CYCLES) ? PULSE_CYCLES : GAP_CYCLES;
    localparam int unsigned TW      = (MAX_CYC > 1) ? $clog2(MAX_CYC) : 1;

    disp_state_e      state_q, state_d;
    logic [AMT_W-1:0] remaining_q, remaining_d;
    logic [AMT_W-1:0] shortfall_q, shortfall_d;
    logic [INV_W-1:0] inv5_q, inv5_d;
    logic [INV_W-1:0] inv10_q, inv10_d;
    logic             eject_5_q, eject_10_q, done_q;
    logic             tmr_load;
    logic [TW-1:0]    tmr_val;
    logic             tmr_expired;

    // One timer serves both the pulse phase and the following gap phase.
    eject_timer #(
        .W(TW)
    ) u_timer (
        .clk      (clk),
        .reset_n  (reset_n),
        .load     (tmr_load),
        .load_val (tmr_val),
        .expired  (tmr_expired)
    );

    // Next-state, datapath updates and timer loads.
    always_comb begin
        state_d     = state_q;
        remaining_d = remaining_q;
        shortfall_d = shortfall_q;
        inv5_d      = inv5_q;
        inv10_d     = inv10_q;
        tmr_load    = 1'b0;
        tmr_val     = '0;
        unique case (state_q)
            StIdle: begin
                // Refill takes priority; req_ready is low while it is present.
                if (refill_valid) begin
                    inv5_d  = refill_cnt5;
                    inv10_d = refill_cnt10;
                end else if (req_valid) begin
                    remaining_d = req_amount;
                    state_d     = StCheck;
                end
            end
            StCheck: begin
                // Inventory is only decremented here, behind a nonzero guard.
                if (remaining_q >= AMT_W'(COIN10) && inv10_q != '0) begin
                    state_d     = StEject10;
                    remaining_d = remaining_q - AMT_W'(COIN10);
                    inv10_d     = inv10_q - 1'b1;
                    tmr_load    = 1'b1;
                    tmr_val     = TW'(PULSE_CYCLES - 1);
                end else if (remaining_q >= AMT_W'(COIN5) && inv5_q != '0) begin
                    state_d     = StEject5;
                    remaining_d = remaining_q - AMT_W'(COIN5);
                    inv5_d      = inv5_q - 1'b1;
                    tmr_load    = 1'b1;
                    tmr_val     = TW'(PULSE_CYCLES - 1);
                end else begin
                    state_d     = StDone;
                    shortfall_d = remaining_q;
                end
            end
            StEject10, StEject5: begin
                if (tmr_expired) begin
                    state_d  = StGap;
                    tmr_load = 1'b1;
                    tmr_val  = TW'(GAP_CYCLES - 1);
                end
            end
            StGap: begin
                if (tmr_expired) begin
                    state_d = StCheck;
                end
            end
            StDone: begin
                state_d = StIdle;
            end
            default: begin
                state_d = StIdle;
            end
        endcase
    end

    // State, datapath and registered solenoid/done outputs.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state_q     <= StIdle;
            remaining_q <= '0;
            shortfall_q <= '0;
            inv5_q      <= INV_W'(INV5_INIT);
            inv10_q     <= INV_W'(INV10_INIT);
            eject_5_q   <= 1'b0;
            eject_10_q  <= 1'b0;
            done_q      <= 1'b0;
        end else begin
            state_q     <= state_d;
            remaining_q <= remaining_d;
            shortfall_q <= shortfall_d;
            inv5_q      <= inv5_d;
            inv10_q     <= inv10_d;
            eject_5_q   <= (state_d == StEject5);
            eject_10_q  <= (state_d == StEject10);
            done_q      <= (state_d == StDone);
        end
    end

    assign req_ready = (state_q == StIdle) && !refill_valid;
    assign busy      = (state_q != StIdle);
    assign eject_5   = eject_5_q;
    assign eject_10  = eject_10_q;
    assign done      = done_q;
    assign shortfall = shortfall_q;
    assign inv5      = inv5_q;
    assign inv10     = inv10_q;

endmodule

// File: tb/tb_change_dispenser.sv
// Self-checking bench for change_dispenser: table-driven payouts plus
// hand-written refill, ignore-refill and mid-eject reset sequences.
module tb_change_dispenser;

    localparam int PULSE  = 4;
    localparam int PERIOD = 9;  // pulse + gap + check per coin

    logic       clk = 1'b0;
    logic       reset_n = 1'b0;
    logic       req_valid = 1'b0;
    logic [7:0] req_amount = '0;
    logic       req_ready;
    logic       refill_valid = 1'b0;
    logic [7:0] refill_cnt5 = '0;
    logic [7:0] refill_cnt10 = '0;
    logic       eject_5, eject_10, busy, done;
    logic [7:0] shortfall, inv5, inv10;

    int n_checks = 0;
    int n_pass   = 0;

    change_dispenser dut (
        .clk          (clk),
        .reset_n      (reset_n),
        .req_valid    (req_valid),
        .req_amount   (req_amount),
        .req_ready    (req_ready),
        .refill_valid (refill_valid),
        .refill_cnt5  (refill_cnt5),
        .refill_cnt10 (refill_cnt10),
        .eject_5      (eject_5),
        .eject_10     (eject_10),
        .busy         (busy),
        .done         (done),
        .shortfall    (shortfall),
        .inv5         (inv5),
        .inv10        (inv10)
    );

    always #5 clk = ~clk;

    typedef struct {
        bit refill;
        int r5;
        int r10;
        int amount;
        int n10;
        int n5;
        int short_amt;
        int inv5;
        int inv10;
        int done_cyc;
    } vec_t;

    vec_t vecs[7];

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got %0d, expected %0d", name, act, exp);
    endtask

    // Wait for done with a cycle budget; returns cycles waited (0 on timeout).
    task automatic wait_done(output int cyc);
        cyc = 0;
        for (int c = 1; c <= 300; c++) begin
            @(negedge clk);
            if (done === 1'b1) begin
                cyc = c;
                break;
            end
        end
    endtask

    task automatic wait_eject10(output bit seen);
        seen = 1'b0;
        for (int c = 0; c < 50; c++) begin
            @(negedge clk);
            if (eject_10 === 1'b1) begin
                seen = 1'b1;
                break;
            end
        end
    endtask

    task automatic run_vec(input int idx, input vec_t v);
        int  done_cyc;
        int  mism;
        int  sf;
        bit  e10, e5;
        int  k;
        if (v.refill) begin
            @(negedge clk);
            refill_valid = 1'b1;
            refill_cnt5  = 8'(v.r5);
            refill_cnt10 = 8'(v.r10);
            @(negedge clk);
            refill_valid = 1'b0;
        end
        @(negedge clk);
        check($sformatf("v%0d_req_ready", idx), 32'(req_ready), 32'd1);
        req_valid  = 1'b1;
        req_amount = 8'(v.amount);
        @(posedge clk);
        done_cyc = 0;
        mism     = 0;
        sf       = -1;
        for (int c = 1; c <= 300 && done_cyc == 0; c++) begin
            @(negedge clk);
            req_valid  = 1'b0;
            req_amount = 8'hff;
            e10 = 1'b0;
            e5  = 1'b0;
            if (c >= 2) begin
                k = c - 2;
                if ((k % PERIOD) < PULSE && (k / PERIOD) < v.n10 + v.n5) begin
                    if ((k / PERIOD) < v.n10) e10 = 1'b1;
                    else e5 = 1'b1;
                end
            end
            if (eject_10 !== e10 || eject_5 !== e5 || busy !== 1'b1) mism++;
            if (done === 1'b1) begin
                done_cyc = c;
                sf       = int'(shortfall);
            end
        end
        check($sformatf("v%0d_done_cycle", idx), 32'(done_cyc), 32'(v.done_cyc));
        check($sformatf("v%0d_eject_pattern_mismatches", idx), 32'(mism), 32'd0);
        check($sformatf("v%0d_shortfall", idx), 32'(sf), 32'(v.short_amt));
        @(negedge clk);
        check($sformatf("v%0d_inv5", idx), 32'(inv5), 32'(v.inv5));
        check($sformatf("v%0d_inv10", idx), 32'(inv10), 32'(v.inv10));
        check($sformatf("v%0d_idle", idx), {30'd0, busy, req_ready}, 32'd1);
        check($sformatf("v%0d_shortfall_held", idx), 32'(shortfall), 32'(v.short_amt));
    endtask

    initial begin
        int  cyc;
        bit  seen;
        int  done_cnt;

        //          refill r5 r10 amt n10 n5 short inv5 inv10 done
        vecs[0] = '{1'b0,  0,  0, 15,  1,  1,  0,  19,  19,  20};
        vecs[1] = '{1'b1,  5,  1, 20,  1,  2,  0,   3,   0,  29};
        vecs[2] = '{1'b1, 20, 20, 13,  1,  0,  3,  20,  19,  11};
        vecs[3] = '{1'b0,  0,  0,  0,  0,  0,  0,  20,  19,   2};
        vecs[4] = '{1'b1,  2,  0, 30,  0,  2, 20,   0,   0,  20};
        vecs[5] = '{1'b1,  3,  4, 35,  3,  1,  0,   2,   1,  38};
        vecs[6] = '{1'b0,  0,  0,  4,  0,  0,  4,   2,   1,   2};

        // Reset state.
        repeat (3) @(negedge clk);
        reset_n = 1'b1;
        @(negedge clk);
        check("rst_req_ready", 32'(req_ready), 32'd1);
        check("rst_busy_done", {30'd0, busy, done}, 32'd0);
        check("rst_ejects", {30'd0, eject_10, eject_5}, 32'd0);
        check("rst_shortfall", 32'(shortfall), 32'd0);
        check("rst_inv5", 32'(inv5), 32'd20);
        check("rst_inv10", 32'(inv10), 32'd20);

        // Refill and request together: refill wins, request taken next cycle.
        refill_valid = 1'b1;
        refill_cnt5  = 8'd7;
        refill_cnt10 = 8'd9;
        req_valid    = 1'b1;
        req_amount   = 8'd5;
        #1;
        check("both_req_ready_low", 32'(req_ready), 32'd0);
        @(negedge clk);
        check("both_not_accepted", 32'(busy), 32'd0);
        check("both_inv5_loaded", 32'(inv5), 32'd7);
        check("both_inv10_loaded", 32'(inv10), 32'd9);
        refill_valid = 1'b0;
        #1;
        check("both_req_ready_after", 32'(req_ready), 32'd1);
        @(negedge clk);
        req_valid = 1'b0;
        check("both_accepted_busy", 32'(busy), 32'd1);
        wait_done(cyc);
        check("both_done_seen", 32'(cyc != 0), 32'd1);
        check("both_shortfall", 32'(shortfall), 32'd0);
        @(negedge clk);
        check("both_inv5_after", 32'(inv5), 32'd6);

        // Refill during an eject pulse is ignored.
        req_valid  = 1'b1;
        req_amount = 8'd10;
        @(negedge clk);
        req_valid = 1'b0;
        wait_eject10(seen);
        check("ign_eject10_seen", 32'(seen), 32'd1);
        refill_valid = 1'b1;
        refill_cnt5  = 8'd0;
        refill_cnt10 = 8'd0;
        repeat (2) @(negedge clk);
        refill_valid = 1'b0;
        check("ign_inv10_mid", 32'(inv10), 32'd8);
        wait_done(cyc);
        check("ign_done_seen", 32'(cyc != 0), 32'd1);
        @(negedge clk);
        check("ign_inv10_after", 32'(inv10), 32'd8);
        check("ign_inv5_after", 32'(inv5), 32'd6);

        // Reset mid-EJECT10 drops the line asynchronously and aborts silently.
        req_valid  = 1'b1;
        req_amount = 8'd20;
        @(negedge clk);
        req_valid = 1'b0;
        wait_eject10(seen);
        check("rst_mid_eject10_seen", 32'(seen), 32'd1);
        #2;
        reset_n = 1'b0;
        #1;
        check("rst_mid_eject10_low", 32'(eject_10), 32'd0);
        check("rst_mid_busy_low", 32'(busy), 32'd0);
        repeat (2) @(negedge clk);
        reset_n = 1'b1;
        done_cnt = 0;
        for (int c = 0; c < 30; c++) begin
            @(negedge clk);
            if (done === 1'b1 || eject_10 === 1'b1 || eject_5 === 1'b1) done_cnt++;
        end
        check("rst_mid_no_activity", 32'(done_cnt), 32'd0);
        check("rst_mid_inv5", 32'(inv5), 32'd20);
        check("rst_mid_inv10", 32'(inv10), 32'd20);
        check("rst_mid_idle", {30'd0, busy, req_ready}, 32'd1);

        // Table-driven payouts, inventory carried from one vector to the next.
        for (int i = 0; i < 7; i++) begin
            run_vec(i, vecs[i]);
        end

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
